// File: rtl/sobel_ctrl_if.sv
// rtl/sobel_ctrl_if.sv - handshake, line-buffer and status bundle for sobel_ctrl
//
// Purpose: groups every non-clock/reset signal of sobel_ctrl so the block and
// its environment connect through one port.
//
// Signals (direction seen from the controller, i.e. the slave modport):
//   start      in   single-cycle frame-start request
//   in_valid   in   upstream pixel available
//   in_ready   out  controller accepts a pixel this cycle
//   lb_wr_en   out  shift line buffers at lb_addr (r3<=r2, r2<=r1, r1<=pixel)
//   lb_addr    out  line-buffer column address
//   out_valid  out  3x3 window complete, Sobel result to be taken
//   out_ready  in   downstream takes the result
//   out_x      out  window-centre column of the current result
//   out_y      out  window-centre row of the current result
//   busy       out  frame in progress
//   done       out  one-cycle end-of-frame pulse
interface sobel_ctrl_if #(
  parameter int AW = 12
) ();

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          lb_wr_en;
  logic [AW-1:0] lb_addr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_x;
  logic [AW-1:0] out_y;
  logic          busy;
  logic          done;

  // Environment side: pixel source, result sink and frame sequencer.
  modport master (
    output start,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  lb_wr_en,
    input  lb_addr,
    input  out_valid,
    input  out_x,
    input  out_y,
    input  busy,
    input  done
  );

  // Controller side.
  modport slave (
    input  start,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output lb_wr_en,
    output lb_addr,
    output out_valid,
    output out_x,
    output out_y,
    output busy,
    output done
  );

endinterface

// File: rtl/sobel_ctrl.sv
// rtl/sobel_ctrl.sv - raster-scan window controller for a 3x3 Sobel datapath
//
// Purpose: accepts one pixel per handshake in raster order, steers the three
// line buffers, and announces a result each time a full 3x3 window is present
// (window centre at col-1,row-1 of the completing pixel).
//
// Parameters:
//   IMG_W  pixels per row (3..4096)
//   IMG_H  rows per image (3..4096)
//   AW     coordinate/address width, 2^AW >= max(IMG_W, IMG_H)
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sobel_ctrl_if slave: start, in_valid/in_ready, lb_wr_en/lb_addr,
//          out_valid/out_ready, out_x/out_y, busy, done
module sobel_ctrl #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  sobel_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [AW-1:0] COL_LAST  = AW'(IMG_W - 1);
  localparam logic [AW-1:0] ROW_LAST  = AW'(IMG_H - 1);
  localparam logic [AW-1:0] ROW_PRIME = AW'(1);
  localparam logic [AW-1:0] COL_WIN   = AW'(2);
  localparam logic [AW-1:0] ONE       = AW'(1);

  state_t        state;
  logic [AW-1:0] col;
  logic [AW-1:0] row;
  logic          out_valid_q;
  logic [AW-1:0] out_x_q;
  logic [AW-1:0] out_y_q;
  logic          done_q;

  logic          stall;
  logic          in_ready_c;
  logic          accept;
  logic          col_wrap;
  logic          window;
  logic          take;
  logic          drained;

  // A result that has not been taken blocks new pixels: accepting one could
  // complete another window and overwrite the pending coordinates.
  assign stall      = out_valid_q & ~bus.out_ready;
  assign in_ready_c = ((state == FILL) || (state == RUN)) & ~stall;
  assign accept     = bus.in_valid & in_ready_c;
  assign col_wrap   = (col == COL_LAST);
  // Rows 0 and 1 are only priming the buffers (FILL); in RUN every row is >= 2,
  // so only the column needs checking.
  assign window     = accept & (state == RUN) & (col >= COL_WIN);
  assign take       = out_valid_q & bus.out_ready;
  assign drained    = ~out_valid_q | bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Result register: a new window may replace a result taken on this
      // same edge, so load has priority over clear.
      if (window) begin
        out_valid_q <= 1'b1;
        out_x_q     <= col - ONE;
        out_y_q     <= row - ONE;
      end else if (take) begin
        out_valid_q <= 1'b0;
      end

      if (accept) begin
        if (col_wrap) begin
          col <= '0;
          row <= row + ONE;
        end else begin
          col <= col + ONE;
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= FILL;
            col   <= '0;
            row   <= '0;
          end
        end
        FILL: begin
          if (accept && col_wrap && (row == ROW_PRIME)) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (accept && col_wrap && (row == ROW_LAST)) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (drained) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.lb_wr_en  = accept;
  assign bus.lb_addr   = col;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: doc/sobel_ctrl.md
SOBEL_CTRL -- requirements
Module: sobel_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 512, meaning pixels per image row; legal range 3..4096.
REQ-002 The block SHALL have parameter IMG_H, default 512, meaning rows per image; legal range 3..4096.
REQ-003 The block SHALL have parameter AW, default 12, meaning width of coordinate and address ports; 2^AW >= max(IMG_W, IMG_H).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1, single-cycle frame-start request.
REQ-007 The block SHALL have port in_valid, input, 1, upstream pixel available.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts a pixel this cycle.
REQ-009 The block SHALL have port lb_wr_en, output, 1, strobe to shift line buffers at lb_addr (r3<=r2, r2<=r1, r1<=pixel).
REQ-010 The block SHALL have port lb_addr, output, AW, line-buffer column address.
REQ-011 The block SHALL have port out_valid, output, 1, the 3x3 window is complete and the Sobel result is to be taken.
REQ-012 The block SHALL have port out_ready, input, 1, downstream takes the result.
REQ-013 The block SHALL have ports out_x and out_y, output, AW each, window-centre coordinate of the current result.
REQ-014 The block SHALL have ports busy, output, 1 (frame in progress), and done, output, 1 (one-cycle end-of-frame pulse).

Function
REQ-015 The FSM SHALL have states IDLE, FILL, RUN and FLUSH; busy = 1 in every state except IDLE.
REQ-016 IDLE->FILL on start=1; start SHALL be ignored in every other state.
REQ-017 Accept: accept = in_valid & in_ready; in_ready = 1 in FILL/RUN when !(out_valid & !out_ready), else 0.
REQ-018 On accept, lb_wr_en SHALL be 1 combinationally and lb_addr SHALL equal col; otherwise lb_wr_en = 0 and lb_addr = col.
REQ-019 Counters col/row SHALL reset to 0 on entering FILL; each accept increments col, wrapping to 0 at IMG_W-1 and incrementing row.
REQ-020 FILL->RUN on the accept with col=IMG_W-1, row=1.
REQ-021 In RUN, an accept with col>=2 SHALL set out_valid=1 on the next edge, with out_x=col-1 and out_y=row-1 captured from that accept.
REQ-022 out_valid SHALL hold, with out_x/out_y stable, until out_valid & out_ready; it then clears unless a new window is produced on the same edge.
REQ-023 Accepts at col 0 or 1 SHALL NOT produce a result; each frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) results in raster order.
REQ-024 The accept with col=IMG_W-1, row=IMG_H-1 SHALL move RUN->FLUSH; in FLUSH in_ready = 0.
REQ-025 FLUSH->IDLE when no result is pending (out_valid=0, or out_valid & out_ready); done SHALL be 1 for exactly that cycle.
REQ-026 Data-path latency SHALL be one clock from window-completing accept to out_valid; throughput one pixel per clock when out_ready=1.
REQ-027 Arithmetic: out_x = col-1 and out_y = row-1 as AW-bit unsigned; no underflow, since RUN guarantees col>=2 and row>=2.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, col=0, row=0, in_ready=0, lb_wr_en=0, lb_addr=0, out_valid=0, out_x=0, out_y=0, busy=0, done=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no done pulse; after release, a new start SHALL begin a clean frame.
REQ-030 After rst_n deassertion the block SHALL remain in IDLE until start.

Verification
REQ-031 Use IMG_W=4, IMG_H=4; start, then 16 pixels with in_valid=1 and out_ready=1 -> 4 results at (1,1),(2,1),(1,2),(2,2); first out_valid 1 clk after 11th accept; done 1 clk after the last result.
REQ-032 Hold out_ready=0 during RUN -> out_valid held, out_x/out_y stable, in_ready=0 and no lb_wr_en until out_ready=1, then the stream resumes with no result lost or duplicated.
REQ-033 Toggle in_valid pseudo-randomly in a full 512x512 frame -> exactly 260100 results, lb_addr sequence 0..511 repeating, one done pulse.
REQ-034 Pulse start while busy -> ignored; result count and coordinates unchanged.
REQ-035 Assert rst_n=0 after row 2, col 3 accepted -> all outputs 0 asynchronously and no done; a following start yields a correct full frame.
REQ-036 Apply start and the first pixel in the same cycle -> in_ready=0 in IDLE, so the pixel is accepted only on the next cycle.
